// File: rtl/obuft_bus_reg_tech.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : obuft_bus_reg_tech                                              |
// | Purpose  : Registered tristate output bus. Fabric requests (valid/ready)   |
// |            feed an output pipeline of LATENCY stages that ends in one      |
// |            OBUFT per pad bit. A direction FSM (HIZ/DRIVE/TURN) enforces a  |
// |            high-Z turnaround gap after every release of the bus.           |
// | Options  : `define OBUFT_BUS_DRVCNT_EN enables the saturating 16-bit       |
// |            accepted-drive-word counter on o_drv_cnt (0 otherwise).         |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module obuft_bus_reg_tech #(
  parameter int WIDTH      = 8,  // pad bus width (>=1)
  parameter int LATENCY    = 1,  // register stages from accept to pad (1..4)
  parameter int TURNAROUND = 2   // minimum high-Z cycles after release (0..15)
) (
  input  logic             i_clk,
  input  logic             i_nrst,
  input  logic             i_req_valid,
  output logic             o_req_ready,
  input  logic             i_req_oe,
  input  logic [WIDTH-1:0] i_req_data,
  output wire  [WIDTH-1:0] o_pad,
  output logic             o_busy,
  output logic [15:0]      o_drv_cnt
);

  localparam logic [1:0] c_st_hiz   = 2'd0;
  localparam logic [1:0] c_st_drive = 2'd1;
  localparam logic [1:0] c_st_turn  = 2'd2;

  // Value loaded into the turnaround counter on release; TURN lasts
  // load+1 cycles, i.e. exactly TURNAROUND cycles.
  localparam logic [3:0] c_turn_load = 4'((TURNAROUND > 0) ? (TURNAROUND - 1) : 0);

  logic [1:0] state_q, state_d;
  logic [3:0] turn_cnt_q, turn_cnt_d;

  // Stage index 0 is the stage loaded on the accepting edge; index
  // LATENCY-1 is the one driving the pads.
  logic [LATENCY-1:0]            stage_oe_q, stage_oe_d;
  logic [LATENCY-1:0][WIDTH-1:0] stage_data_q, stage_data_d;

  logic accept;

  assign o_req_ready = (state_q != c_st_turn);
  assign accept      = i_req_valid & o_req_ready;
  assign o_busy      = (state_q != c_st_hiz) | (|stage_oe_q);

  // Direction FSM next-state and turnaround countdown.
  always_comb begin
    state_d    = state_q;
    turn_cnt_d = turn_cnt_q;
    case (state_q)
      c_st_hiz: begin
        if (accept && i_req_oe) begin
          state_d = c_st_drive;
        end
      end
      c_st_drive: begin
        if (accept && !i_req_oe) begin
          if (TURNAROUND > 0) begin
            state_d    = c_st_turn;
            turn_cnt_d = c_turn_load;
          end else begin
            state_d = c_st_hiz;
          end
        end
      end
      c_st_turn: begin
        if (turn_cnt_q == 4'd0) begin
          state_d = c_st_hiz;
        end else begin
          turn_cnt_d = turn_cnt_q - 4'd1;
        end
      end
      default: begin
        state_d    = c_st_hiz;
        turn_cnt_d = 4'd0;
      end
    endcase
  end

  // Output pipeline: stage 0 captures accepted requests (a release keeps the
  // old data, only oe drops); later stages shift unconditionally.
  always_comb begin
    stage_oe_d   = stage_oe_q;
    stage_data_d = stage_data_q;
    if (accept) begin
      stage_oe_d[0] = i_req_oe;
      if (i_req_oe) begin
        stage_data_d[0] = i_req_data;
      end
    end
    for (int s = 1; s < LATENCY; s++) begin
      stage_oe_d[s]   = stage_oe_q[s-1];
      stage_data_d[s] = stage_data_q[s-1];
    end
  end

  // State, turnaround counter and pipeline registers.
  always_ff @(posedge i_clk or negedge i_nrst) begin
    if (!i_nrst) begin
      state_q      <= c_st_hiz;
      turn_cnt_q   <= 4'd0;
      stage_oe_q   <= '0;
      stage_data_q <= '0;
    end else begin
      state_q      <= state_d;
      turn_cnt_q   <= turn_cnt_d;
      stage_oe_q   <= stage_oe_d;
      stage_data_q <= stage_data_d;
    end
  end

  // One tristate driver per pad bit; T is the inverse of the last stage oe,
  // so reset releases the pads without waiting for a clock.
  for (genvar g = 0; g < WIDTH; g++) begin : g_obuft
    assign o_pad[g] = stage_oe_q[LATENCY-1] ? stage_data_q[LATENCY-1][g] : 1'bz;
  end

`ifdef OBUFT_BUS_DRVCNT_EN
  logic [15:0] drv_cnt_q, drv_cnt_d;

  // Saturating count of accepted drive words.
  always_comb begin
    drv_cnt_d = drv_cnt_q;
    if (accept && i_req_oe && (drv_cnt_q != 16'hFFFF)) begin
      drv_cnt_d = drv_cnt_q + 16'd1;
    end
  end

  // Drive-word counter register; cleared only by reset.
  always_ff @(posedge i_clk or negedge i_nrst) begin
    if (!i_nrst) begin
      drv_cnt_q <= 16'd0;
    end else begin
      drv_cnt_q <= drv_cnt_d;
    end
  end

  assign o_drv_cnt = drv_cnt_q;
`else
  assign o_drv_cnt = 16'd0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_obuft_bus_reg_tech.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : tb_obuft_bus_reg_tech                                           |
// | Purpose  : Self-checking bench for obuft_bus_reg_tech. Each configuration  |
// |            is instantiated twice, once on a pulled-up and once on a        |
// |            pulled-down pad net, so a released pad reads FF/00 while a      |
// |            driven pad reads the same value on both.                        |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module tb_obuft_bus_reg_tech;

  logic clk = 1'b0;
  logic nrst;
  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;

  // Configuration A: LATENCY=1, TURNAROUND=2
  logic        a_valid, a_oe;
  logic [7:0]  a_data;
  tri1  [7:0]  a_pad_up;
  tri0  [7:0]  a_pad_dn;
  logic        a_rdy, a_rdy2, a_busy, a_busy2;
  logic [15:0] a_cnt, a_cnt2;

  // Configuration B: LATENCY=3, TURNAROUND=0
  logic        b_valid, b_oe;
  logic [7:0]  b_data;
  tri1  [7:0]  b_pad_up;
  tri0  [7:0]  b_pad_dn;
  logic        b_rdy, b_rdy2, b_busy, b_busy2;
  logic [15:0] b_cnt, b_cnt2;

  obuft_bus_reg_tech #(.WIDTH(8), .LATENCY(1), .TURNAROUND(2)) u_a_up (
    .i_clk(clk), .i_nrst(nrst), .i_req_valid(a_valid), .o_req_ready(a_rdy),
    .i_req_oe(a_oe), .i_req_data(a_data), .o_pad(a_pad_up), .o_busy(a_busy),
    .o_drv_cnt(a_cnt));
  obuft_bus_reg_tech #(.WIDTH(8), .LATENCY(1), .TURNAROUND(2)) u_a_dn (
    .i_clk(clk), .i_nrst(nrst), .i_req_valid(a_valid), .o_req_ready(a_rdy2),
    .i_req_oe(a_oe), .i_req_data(a_data), .o_pad(a_pad_dn), .o_busy(a_busy2),
    .o_drv_cnt(a_cnt2));
  obuft_bus_reg_tech #(.WIDTH(8), .LATENCY(3), .TURNAROUND(0)) u_b_up (
    .i_clk(clk), .i_nrst(nrst), .i_req_valid(b_valid), .o_req_ready(b_rdy),
    .i_req_oe(b_oe), .i_req_data(b_data), .o_pad(b_pad_up), .o_busy(b_busy),
    .o_drv_cnt(b_cnt));
  obuft_bus_reg_tech #(.WIDTH(8), .LATENCY(3), .TURNAROUND(0)) u_b_dn (
    .i_clk(clk), .i_nrst(nrst), .i_req_valid(b_valid), .o_req_ready(b_rdy2),
    .i_req_oe(b_oe), .i_req_data(b_data), .o_pad(b_pad_dn), .o_busy(b_busy2),
    .o_drv_cnt(b_cnt2));

  typedef struct {
    logic       valid;
    logic       oe;
    logic [7:0] data;
    logic       rdy;   // ready expected before the edge
    logic       pz;    // pads expected Z after the edge
    logic [7:0] pad;   // pad value after the edge when driven
    logic       busy;  // busy after the edge
  } vec_t;

  typedef struct {
    logic       z;
    logic [7:0] v;
  } pexp_t;

  vec_t        vecs[13];
  pexp_t       sbq[$];
  logic [15:0] a_cnt_m, b_cnt_m;
  logic        b_st_oe, b_drive_m;
  logic [7:0]  b_st_data;

  function automatic logic [15:0] sat_inc(input logic [15:0] c);
`ifdef OBUFT_BUS_DRVCNT_EN
    return (c == 16'hFFFF) ? c : c + 16'd1;
`else
    return 16'd0;
`endif
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic chk_pad(input string nm, input logic [7:0] up, input logic [7:0] dn,
                         input logic exp_z, input logic [7:0] exp_v);
    logic ok;
    n_chk++;
    ok = exp_z ? (up === 8'hFF && dn === 8'h00) : (up === exp_v && dn === exp_v);
    if (!ok) begin
      n_fail++;
      $display("FAIL %s: pad pullup=%h pulldown=%h expected %s", nm, up, dn,
               exp_z ? "Z" : $sformatf("%h", exp_v));
    end
  endtask

  task automatic chk_a(input string nm, input logic exp_z, input logic [7:0] exp_v,
                       input logic exp_busy);
    chk_pad({nm, " pad"}, a_pad_up, a_pad_dn, exp_z, exp_v);
    chk({nm, " busy"}, {30'd0, a_busy, a_busy2}, {30'd0, exp_busy, exp_busy});
    chk({nm, " cnt"}, {a_cnt, a_cnt2}, {a_cnt_m, a_cnt_m});
  endtask

  task automatic chk_a_rdy(input string nm, input logic exp_rdy);
    chk({nm, " ready"}, {30'd0, a_rdy, a_rdy2}, {30'd0, exp_rdy, exp_rdy});
  endtask

  // One cycle on configuration B with a scoreboard of pad values: the bench
  // models stage 1 and the queue delays it by LATENCY-1 cycles to the pad.
  task automatic b_cycle(input logic v, input logic oe, input logic [7:0] d, input string nm);
    pexp_t e;
    logic  any_oe;
    b_valid = v; b_oe = oe; b_data = d;
    #1;
    chk({nm, " ready"}, {30'd0, b_rdy, b_rdy2}, 32'd3);
    if (v) begin
      b_st_oe   = oe;
      b_drive_m = oe;
      if (oe) begin
        b_st_data = d;
        b_cnt_m   = sat_inc(b_cnt_m);
      end
    end
    step();
    sbq.push_back('{z: ~b_st_oe, v: b_st_data});
    e = sbq.pop_front();
    chk_pad({nm, " pad"}, b_pad_up, b_pad_dn, e.z, e.v);
    any_oe = b_drive_m | ~e.z;
    foreach (sbq[i]) any_oe = any_oe | ~sbq[i].z;
    chk({nm, " busy"}, {30'd0, b_busy, b_busy2}, {30'd0, any_oe, any_oe});
    chk({nm, " cnt"}, {b_cnt, b_cnt2}, {b_cnt_m, b_cnt_m});
  endtask

  initial begin
    a_valid = 0; a_oe = 0; a_data = 0;
    b_valid = 0; b_oe = 0; b_data = 0;
    a_cnt_m = 0; b_cnt_m = 0;
    nrst = 1'b1;
    #2 nrst = 1'b0;
    #1;
    // Reset state before any clock edge
    chk_a("reset0", 1'b1, 8'h00, 1'b0);
    chk_a_rdy("reset0", 1'b1);
    chk_pad("reset0 B pad", b_pad_up, b_pad_dn, 1'b1, 8'h00);
    step(); step();
    #3 nrst = 1'b1;
    step();

    // Configuration A vectors: idle release, streaming, turnaround=2
    vecs[0]  = '{1'b1, 1'b0, 8'hFF, 1'b1, 1'b1, 8'h00, 1'b0};
    vecs[1]  = '{1'b1, 1'b1, 8'h01, 1'b1, 1'b0, 8'h01, 1'b1};
    vecs[2]  = '{1'b1, 1'b1, 8'h02, 1'b1, 1'b0, 8'h02, 1'b1};
    vecs[3]  = '{1'b1, 1'b1, 8'h03, 1'b1, 1'b0, 8'h03, 1'b1};
    vecs[4]  = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 8'h03, 1'b1};
    vecs[5]  = '{1'b1, 1'b0, 8'h55, 1'b1, 1'b1, 8'h00, 1'b1};
    vecs[6]  = '{1'b1, 1'b1, 8'hAA, 1'b0, 1'b1, 8'h00, 1'b1};
    vecs[7]  = '{1'b1, 1'b1, 8'hAA, 1'b0, 1'b1, 8'h00, 1'b0};
    vecs[8]  = '{1'b1, 1'b1, 8'hAA, 1'b1, 1'b0, 8'hAA, 1'b1};
    vecs[9]  = '{1'b1, 1'b0, 8'h00, 1'b1, 1'b1, 8'h00, 1'b1};
    vecs[10] = '{1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 8'h00, 1'b1};
    vecs[11] = '{1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 8'h00, 1'b0};
    vecs[12] = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 8'h00, 1'b0};

    for (int i = 0; i < 13; i++) begin
      a_valid = vecs[i].valid; a_oe = vecs[i].oe; a_data = vecs[i].data;
      #1;
      chk_a_rdy($sformatf("A[%0d]", i), vecs[i].rdy);
      if (vecs[i].valid && vecs[i].rdy && vecs[i].oe) a_cnt_m = sat_inc(a_cnt_m);
      step();
      chk_a($sformatf("A[%0d]", i), vecs[i].pz, vecs[i].pad, vecs[i].busy);
    end
    a_valid = 0;

    // Configuration B: latency 3 and turnaround 0 through the scoreboard
    sbq.delete();
    b_st_oe = 1'b0; b_st_data = 8'h00; b_drive_m = 1'b0;
    for (int i = 0; i < 2; i++) sbq.push_back('{z: 1'b1, v: 8'h00});
    b_cycle(1'b0, 1'b0, 8'h00, "B idle");
    b_cycle(1'b1, 1'b1, 8'h3C, "B lat k");
    b_cycle(1'b0, 1'b0, 8'h00, "B lat k+1");
    b_cycle(1'b0, 1'b0, 8'h00, "B lat k+2");
    b_cycle(1'b0, 1'b0, 8'h00, "B hold");
    b_cycle(1'b1, 1'b0, 8'h77, "B release");
    b_cycle(1'b1, 1'b1, 8'h5A, "B redrive");
    b_cycle(1'b1, 1'b1, 8'h5B, "B stream");
    b_cycle(1'b0, 1'b0, 8'h00, "B idle2");
    b_cycle(1'b1, 1'b0, 8'h00, "B release2");
    for (int i = 0; i < 4; i++) b_cycle(1'b0, 1'b0, 8'h00, $sformatf("B drain%0d", i));
    b_valid = 0;

    // Reset mid-DRIVE with A5 on the pads: released without a clock
    a_valid = 1; a_oe = 1; a_data = 8'hA5;
    a_cnt_m = sat_inc(a_cnt_m);
    step();
    a_valid = 0;
    chk_a("drive A5", 1'b0, 8'hA5, 1'b1);
    #2 nrst = 1'b0;
    #1;
    a_cnt_m = 16'd0;
    chk_a("rst drive", 1'b1, 8'h00, 1'b0);
    chk_a_rdy("rst drive", 1'b1);
    #2 nrst = 1'b1;

    // Reset mid-TURN: no turnaround remains pending afterwards
    step();
    a_valid = 1; a_oe = 1; a_data = 8'h11;
    a_cnt_m = sat_inc(a_cnt_m);
    step();
    chk_a("turn pre", 1'b0, 8'h11, 1'b1);
    a_oe = 0;
    step();
    a_valid = 0;
    chk_a_rdy("in turn", 1'b0);
    #2 nrst = 1'b0;
    #1;
    a_cnt_m = 16'd0;
    chk_a("rst turn", 1'b1, 8'h00, 1'b0);
    chk_a_rdy("rst turn", 1'b1);
    #1 nrst = 1'b1;
    #1;
    a_valid = 1; a_oe = 1; a_data = 8'h22;
    chk_a_rdy("post rst", 1'b1);
    a_cnt_m = sat_inc(a_cnt_m);
    step();
    chk_a("post rst", 1'b0, 8'h22, 1'b1);

    // Counter saturation: 65537 further accepted drive words
    for (int i = 0; i < 65537; i++) begin
      a_data = 8'(i);
      a_cnt_m = sat_inc(a_cnt_m);
      step();
    end
    a_valid = 0;
    chk_a("cnt sat", 1'b0, 8'(65536), 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
